// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   MM:SS stopwatch kept as four BCD digits, driven by the divider's 1 Hz and
//   2 Hz single-cycle enables. A RUN / PAUSED / ADJ mode machine selects
//   between free counting (1 Hz), holding, and manual field adjustment (2 Hz).
//   All outputs come straight from registers or from decodes of registered state.
//
// Ports
//   clk_in       system clock
//   rst          synchronous, active-high reset
//   tick_1hz     1 Hz count enable (used in RUN)
//   tick_2hz     2 Hz adjust enable (used in ADJ)
//   pause_pulse  debounced pause button pulse
//   adj          adjust mode request (level)
//   sel          adjust field select: 0 = minutes, 1 = seconds
//   min_tens, min_ones, sec_tens, sec_ones   BCD time digits
//   running      state is RUN
//   adjusting    state is ADJ
//   blink_field  [1] blank minutes, [0] blank seconds in the blink-off phase
//   blink_phase  toggles on each tick_2hz while adjusting
module stopwatch_counter #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       adjusting,
  output logic [1:0] blink_field,
  output logic       blink_phase
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_ADJ    = 2'd2;

  localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

  logic [1:0] r_state;
  logic       r_paused_saved;
  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic       r_blink_phase;
  logic [1:0] r_blink_field;

  logic [1:0] w_state_next;
  logic       w_saved_next;

  // Mode machine; adj level changes take priority and swallow a coincident pause pulse.
  always_comb begin
    w_state_next = r_state;
    w_saved_next = r_paused_saved;
    if (adj && (r_state != ST_ADJ)) begin
      w_state_next = ST_ADJ;
      w_saved_next = (r_state == ST_PAUSED);
    end else if (!adj && (r_state == ST_ADJ)) begin
      w_state_next = r_paused_saved ? ST_PAUSED : ST_RUN;
    end else if (pause_pulse) begin
      case (r_state)
        ST_RUN:    w_state_next = ST_PAUSED;
        ST_PAUSED: w_state_next = ST_RUN;
        ST_ADJ:    w_saved_next = ~r_paused_saved;
        default:   w_state_next = ST_RUN;
      endcase
    end else if ((r_state != ST_RUN) && (r_state != ST_PAUSED) && (r_state != ST_ADJ)) begin
      w_state_next = ST_RUN;
    end
  end

  // Digit step logic: every wrap test uses >= so an illegal code steps to 0.
  logic w_so_wrap, w_st_wrap, w_mo_wrap, w_min_wrap;
  logic w_in_run, w_in_adj, w_do_sec, w_do_min;

  assign w_so_wrap  = (r_sec_ones >= 4'd9);
  assign w_st_wrap  = (r_sec_tens >= 4'd5);
  assign w_mo_wrap  = (r_min_ones >= 4'd9);
  // Packed BCD digits compare in numeric order, so MM >= MIN_MAX is a plain compare.
  assign w_min_wrap = ({r_min_tens, r_min_ones} >= {MAX_TENS, MAX_ONES});

  assign w_in_run = (r_state == ST_RUN);
  assign w_in_adj = (r_state == ST_ADJ);
  assign w_do_sec = (w_in_run && tick_1hz) || (w_in_adj && tick_2hz && sel);
  // Seconds rollover carries into minutes only in RUN; ADJ steps minutes directly.
  assign w_do_min = (w_in_run && tick_1hz && w_so_wrap && w_st_wrap) ||
                    (w_in_adj && tick_2hz && !sel);

  logic [3:0] w_sec_ones_next, w_sec_tens_next, w_min_ones_next, w_min_tens_next;

  always_comb begin
    w_sec_ones_next = r_sec_ones;
    w_sec_tens_next = r_sec_tens;
    w_min_ones_next = r_min_ones;
    w_min_tens_next = r_min_tens;
    if (w_do_sec) begin
      w_sec_ones_next = w_so_wrap ? '0 : r_sec_ones + 4'd1;
      if (w_so_wrap)
        w_sec_tens_next = w_st_wrap ? '0 : r_sec_tens + 4'd1;
    end
    if (w_do_min) begin
      if (w_min_wrap) begin
        w_min_tens_next = '0;
        w_min_ones_next = '0;
      end else if (w_mo_wrap) begin
        w_min_ones_next = '0;
        w_min_tens_next = (r_min_tens >= 4'd9) ? '0 : r_min_tens + 4'd1;
      end else begin
        w_min_ones_next = r_min_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_paused_saved <= 1'b0;
      r_min_tens     <= '0;
      r_min_ones     <= '0;
      r_sec_tens     <= '0;
      r_sec_ones     <= '0;
      r_blink_phase  <= 1'b0;
      r_blink_field  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_paused_saved <= w_saved_next;
      r_min_tens     <= w_min_tens_next;
      r_min_ones     <= w_min_ones_next;
      r_sec_tens     <= w_sec_tens_next;
      r_sec_ones     <= w_sec_ones_next;
      // Phase only runs while staying in ADJ; leaving or outside ADJ it is 0.
      if (w_in_adj && (w_state_next == ST_ADJ))
        r_blink_phase <= r_blink_phase ^ tick_2hz;
      else
        r_blink_phase <= 1'b0;
      // Keyed to next state so the field tracks the registered adjusting flag.
      if (w_state_next == ST_ADJ)
        r_blink_field <= sel ? 2'b01 : 2'b10;
      else
        r_blink_field <= 2'b00;
    end
  end

  assign min_tens    = r_min_tens;
  assign min_ones    = r_min_ones;
  assign sec_tens    = r_sec_tens;
  assign sec_ones    = r_sec_ones;
  assign running     = (r_state == ST_RUN);
  assign adjusting   = (r_state == ST_ADJ);
  assign blink_field = r_blink_field;
  assign blink_phase = r_blink_phase;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Consumer of the single-cycle tick enables produced by the clock divider. It keeps stopwatch time as four BCD digits, MM:SS, and runs a RUN / PAUSED / ADJUST mode machine. In adjust mode it exposes a blink field and blink phase for the display scanner. It sits between the divider and the seven-segment display multiplexer, all in the clk_in domain.

Parameters:
MIN_MAX, 59, maximum minutes value before wrap to 00; legal range 1..99.

Ports:
clk_in  input  1  system clock (100 MHz)
rst  input  1  reset, synchronous, active-high
tick_1hz  input  1  one-cycle enable pulse at 1 Hz
tick_2hz  input  1  one-cycle enable pulse at 2 Hz
pause_pulse  input  1  one-cycle debounced pause button pulse
adj  input  1  level: adjust mode request
sel  input  1  level: adjust field select; 0 = minutes, 1 = seconds
min_tens  output  4  BCD minutes tens digit
min_ones  output  4  BCD minutes ones digit
sec_tens  output  4  BCD seconds tens digit (0..5)
sec_ones  output  4  BCD seconds ones digit
running  output  1  high when state == RUN
adjusting  output  1  high when state == ADJ
blink_field  output  2  [1] = blank minutes, [0] = blank seconds during blink-off phase
blink_phase  output  1  toggles on each tick_2hz while in ADJ

Behaviour:
- Clock and reset: clk_in clocks everything. rst is synchronous, active-high, and overrides every other input.
- Reset values: all digits 0, state RUN, paused_saved 0, blink_phase 0, blink_field 00, running 1, adjusting 0.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- State register encodings: RUN, PAUSED, ADJ.
- Input sampling: inputs sampled at cycle n update state and digits at the edge ending cycle n. Counting at cycle n uses the state registered at cycle n, not the next state.
- Transitions, evaluated in priority order:
  - adj=1 and state != ADJ: go to ADJ; paused_saved <= (state == PAUSED).
  - adj=0 and state == ADJ: go to PAUSED if paused_saved, else RUN.
  - state RUN and pause_pulse: go to PAUSED.
  - state PAUSED and pause_pulse: go to RUN.
  - state ADJ and pause_pulse: toggle paused_saved only.
- If a pause_pulse arrives in the same cycle adj changes level, the adj transition wins and the pulse is dropped.
- RUN counting, on tick_1hz:
  - sec_ones increments; 9 -> 0 carries into sec_tens.
  - sec_tens 5 with carry -> 0, carrying into minutes.
  - Minutes increment as BCD; the minutes value MIN_MAX with carry -> 00.
  - 59:59 (default) -> 00:00 in one edge.
  - tick_2hz is ignored in RUN.
- RUN, tick_1hz and pause_pulse in the same cycle: the increment is applied and state becomes PAUSED.
- PAUSED: digits hold; both ticks ignored.
- ADJ counting, on tick_2hz:
  - sel=0: minutes increment, wrapping MIN_MAX -> 00. Seconds untouched.
  - sel=1: seconds increment, wrapping 59 -> 00, with no carry into minutes.
  - tick_1hz is ignored in ADJ.
  - sel changes take effect on the next tick_2hz.
- blink_phase:
  - Toggles on each tick_2hz while state == ADJ.
  - Forced to 0 in the cycle the state leaves ADJ.
- blink_field:
  - 10 when state == ADJ and sel == 0.
  - 01 when state == ADJ and sel == 1.
  - 00 otherwise.
  - Registered, so it lags sel by one cycle.
- Digit invariants: every digit is always a valid BCD code; the seconds tens digit never exceeds 5; the minutes value never exceeds MIN_MAX. Each digit counter rejects illegal codes by design, not by masking.
- Reset mid-operation (any state, including mid-ADJ): the next edge restores all reset values.

Test Plan:
- rst held 2 cycles, then 65 tick_1hz pulses spaced 4 cycles apart -> digits 01:05, running = 1.
- Preload 59:58 via ADJ, exit to RUN, 3 tick_1hz pulses -> 59:59, then 00:00, then 00:01.
- RUN at 00:10; pause_pulse coincident with tick_1hz -> 00:11 and running = 0. Further ticks hold 00:11. A second pause_pulse -> running = 1.
- adj=1, sel=1, 50 tick_2hz pulses from 00:10 -> 00:00 with minutes untouched and blink_field = 01. With sel=0, 3 pulses -> 03:00 and blink_field = 10. blink_phase toggles each pulse.
- Enter ADJ from PAUSED, pause_pulse once while in ADJ, then drop adj -> state RUN, blink_phase = 0, adjusting = 0.
- Mid-ADJ at 12:34, assert rst for one cycle -> 00:00, running = 1, blink_field = 00. With MIN_MAX = 99, 99:59 + tick_1hz -> 00:00.
